// File: rtl/countdown_7seg_display.sv
// countdown_7seg_display: loadable countdown with sequential double-dabble BCD conversion to active-low 7-segment digits.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero digit.
module countdown_7seg_display #(
   parameter int WIDTH  = 7,
   parameter int DIGITS = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [WIDTH-1:0]      load_val,
   input  logic                  tick,
   output logic [WIDTH-1:0]      count,
   output logic                  zero,
   output logic [7*DIGITS-1:0]   seg,
   output logic                  seg_valid
);
   localparam int BW = 4*DIGITS;
   localparam int CW = $clog2(WIDTH+1);
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0]    count_nxt, sh;
   logic [BW-1:0]       bcd, bcd_adj;
   logic                ovf, restart, do_load, do_shift, do_done;
   logic [CW-1:0]       cnt;
   logic [7*DIGITS-1:0] seg_dec;
`ifdef LEADING_ZERO_BLANK_EN
   logic                lead;
`endif
   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0:    dec = 7'b1000000;
         4'd1:    dec = 7'b1111001;
         4'd2:    dec = 7'b0100100;
         4'd3:    dec = 7'b0110000;
         4'd4:    dec = 7'b0011001;
         4'd5:    dec = 7'b0010010;
         4'd6:    dec = 7'b0000010;
         4'd7:    dec = 7'b1111000;
         4'd8:    dec = 7'b0000000;
         default: dec = 7'b0010000;
      endcase
   endfunction
   // a restart is any value change, so a tick at zero never restarts conversion
   assign count_nxt = load ? load_val : (tick && count != '0) ? count - WIDTH'(1) : count;
   assign restart   = count_nxt != count;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         zero  <= 1'b1;
      end else begin
         count <= count_nxt;
         zero  <= count_nxt == '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_nxt;
   end
   always_comb begin
      state_nxt = restart          ? LOAD :
                  state == IDLE    ? IDLE :
                  state == LOAD    ? SHIFT :
                  state == SHIFT   ? (cnt == CW'(WIDTH-1) ? DONE : SHIFT) : IDLE;
   end
   always_comb begin
      do_load  = state == LOAD;
      do_shift = state == SHIFT;
      do_done  = state == DONE;
   end
   for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      assign bcd_adj[4*k+:4] = bcd[4*k+:4] >= 4'd5 ? bcd[4*k+:4] + 4'd3 : bcd[4*k+:4];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh  <= '0;
         bcd <= '0;
         ovf <= 1'b0;
         cnt <= '0;
      end else if (do_load) begin
         sh  <= count;
         bcd <= '0;
         ovf <= 1'b0;
         cnt <= '0;
      end else if (do_shift) begin
         sh  <= sh << 1;
         bcd <= {bcd_adj[BW-2:0], sh[WIDTH-1]};
         ovf <= ovf | bcd_adj[BW-1];
         cnt <= cnt + CW'(1);
      end
   end
   // overflow dashes take precedence over any blanking
   always_comb begin
      seg_dec = '1;
`ifdef LEADING_ZERO_BLANK_EN
      lead = 1'b1;
`endif
      for (int k = DIGITS-1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
         if (bcd[4*k+:4] != 4'd0 || k == 0) lead = 1'b0;
         seg_dec[7*k+:7] = ovf ? 7'b0111111 : lead ? 7'b1111111 : dec(bcd[4*k+:4]);
`else
         seg_dec[7*k+:7] = ovf ? 7'b0111111 : dec(bcd[4*k+:4]);
`endif
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg       <= '1;
         seg_valid <= 1'b0;
      end else begin
         if (do_done) seg <= seg_dec;
         seg_valid <= restart ? 1'b0 : do_done ? 1'b1 : seg_valid;
      end
   end
endmodule
